// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decode fields, register file and writeback
// inputs driven by the master, EX-slot outputs driven by the stage.
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          id_valid;
    logic [3:0]    id_opcode;
    logic [RW-1:0] id_src1;
    logic [RW-1:0] id_src2;
    logic [RW-1:0] id_dst;
    logic [DW-1:0] id_imm;
    logic          id_wen;
    logic          id_memread;
    logic          id_memwrite;
    logic [DW-1:0] rf_data1;
    logic [DW-1:0] rf_data2;
    logic [RW-1:0] wb_dst;
    logic          wb_wen;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          mem_stall;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [RW-1:0] ex_src1;
    logic [RW-1:0] ex_src2;
    logic [RW-1:0] ex_dst;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_data1;
    logic [DW-1:0] ex_data2;
    logic          ex_wen;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          stall_id;
    logic [15:0]   bubble_cnt;

    modport master (
        output id_valid, id_opcode, id_src1, id_src2, id_dst,
        output id_imm, id_wen, id_memread, id_memwrite,
        output rf_data1, rf_data2, wb_dst, wb_wen, wb_data,
        output flush, mem_stall,
        input  ex_valid, ex_opcode, ex_src1, ex_src2, ex_dst,
        input  ex_imm, ex_data1, ex_data2,
        input  ex_wen, ex_memread, ex_memwrite,
        input  stall_id, bubble_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_src1, id_src2, id_dst,
        input  id_imm, id_wen, id_memread, id_memwrite,
        input  rf_data1, rf_data2, wb_dst, wb_wen, wb_data,
        input  flush, mem_stall,
        output ex_valid, ex_opcode, ex_src1, ex_src2, ex_dst,
        output ex_imm, ex_data1, ex_data2,
        output ex_wen, ex_memread, ex_memwrite,
        output stall_id, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, flush and memory stall.
// Define WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module id_ex_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave io
);
    typedef struct packed {
        logic          valid;
        logic [3:0]    opcode;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic [RW-1:0] dst;
        logic [DW-1:0] imm;
        logic [DW-1:0] data1;
        logic [DW-1:0] data2;
        logic          wen;
        logic          memread;
        logic          memwrite;
    } ex_t;

    ex_t           ex_q, ex_d;
    logic [15:0]   bubble_q, bubble_d;
    logic          haz;
    logic          byp1, byp2;
    logic [DW-1:0] op1, op2;

    assign haz = ex_q.valid & ex_q.memread & (ex_q.dst != '0)
               & io.id_valid
               & ((ex_q.dst == io.id_src1) | (ex_q.dst == io.id_src2));

    assign io.stall_id = io.mem_stall | (haz & ~io.flush);

`ifdef WB_BYPASS_EN
    assign byp1 = io.wb_wen & (io.wb_dst != '0) & (io.wb_dst == io.id_src1);
    assign byp2 = io.wb_wen & (io.wb_dst != '0) & (io.wb_dst == io.id_src2);
`else
    logic unused_wb;
    assign unused_wb = ^{io.wb_wen, io.wb_dst, io.wb_data};
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // R0 reads as zero even if a bypass would match
    always_comb begin
        op1 = byp1 ? io.wb_data : io.rf_data1;
        op2 = byp2 ? io.wb_data : io.rf_data2;
        if (io.id_src1 == '0) op1 = '0;
        if (io.id_src2 == '0) op2 = '0;
    end

    always_comb begin
        ex_d     = ex_q;
        bubble_d = bubble_q;
        priority case (1'b1)
            io.mem_stall: ;
            io.flush: ex_d = '0;
            haz: begin
                ex_d = '0;
                if (bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
            end
            default: begin
                ex_d.valid    = io.id_valid;
                ex_d.opcode   = io.id_opcode;
                ex_d.src1     = io.id_src1;
                ex_d.src2     = io.id_src2;
                ex_d.dst      = io.id_dst;
                ex_d.imm      = io.id_imm;
                ex_d.data1    = op1;
                ex_d.data2    = op2;
                ex_d.wen      = io.id_wen & io.id_valid;
                ex_d.memread  = io.id_memread & io.id_valid;
                ex_d.memwrite = io.id_memwrite & io.id_valid;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= '0;
            bubble_q <= '0;
        end else begin
            ex_q     <= ex_d;
            bubble_q <= bubble_d;
        end
    end

    assign io.ex_valid    = ex_q.valid;
    assign io.ex_opcode   = ex_q.opcode;
    assign io.ex_src1     = ex_q.src1;
    assign io.ex_src2     = ex_q.src2;
    assign io.ex_dst      = ex_q.dst;
    assign io.ex_imm      = ex_q.imm;
    assign io.ex_data1    = ex_q.data1;
    assign io.ex_data2    = ex_q.data2;
    assign io.ex_wen      = ex_q.wen;
    assign io.ex_memread  = ex_q.memread;
    assign io.ex_memwrite = ex_q.memwrite;
    assign io.bubble_cnt  = bubble_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each
// edge's EX slot, the expectation is queued and checked after the edge.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(16), .RW(4)) io ();

    id_ex_stage #(.DW(16), .RW(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  dst;
        logic [15:0] imm;
        logic [15:0] d1;
        logic [15:0] d2;
        logic        wen;
        logic        mr;
        logic        mw;
        logic [15:0] cnt;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] opnd(input logic [3:0] s,
                                         input logic [15:0] rf);
        if (s == 4'd0) return 16'd0;
`ifdef WB_BYPASS_EN
        if (io.wb_wen && io.wb_dst != 4'd0 && io.wb_dst == s)
            return io.wb_data;
`endif
        return rf;
    endfunction

    task automatic id(input logic v, input logic [3:0] op,
                      input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] d, input logic [15:0] imm,
                      input logic wen, input logic mr, input logic mw,
                      input logic [15:0] r1, input logic [15:0] r2);
        io.id_valid    = v;
        io.id_opcode   = op;
        io.id_src1     = s1;
        io.id_src2     = s2;
        io.id_dst      = d;
        io.id_imm      = imm;
        io.id_wen      = wen;
        io.id_memread  = mr;
        io.id_memwrite = mw;
        io.rf_data1    = r1;
        io.rf_data2    = r2;
    endtask

    task automatic step();
        exp_t e;
        logic hz;
        #1;
        hz = m.v && m.mr && (m.dst != 4'd0) && io.id_valid
             && (m.dst == io.id_src1 || m.dst == io.id_src2);
        chk("stall_id", 32'(io.stall_id),
            32'(io.mem_stall || (hz && !io.flush)));
        e = m;
        if (io.mem_stall) begin
        end else if (io.flush) begin
            e = '0;
            e.cnt = m.cnt;
        end else if (hz) begin
            e = '0;
            e.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
        end else begin
            e.v   = io.id_valid;
            e.op  = io.id_opcode;
            e.s1  = io.id_src1;
            e.s2  = io.id_src2;
            e.dst = io.id_dst;
            e.imm = io.id_imm;
            e.d1  = opnd(io.id_src1, io.rf_data1);
            e.d2  = opnd(io.id_src2, io.rf_data2);
            e.wen = io.id_wen & io.id_valid;
            e.mr  = io.id_memread & io.id_valid;
            e.mw  = io.id_memwrite & io.id_valid;
        end
        sb.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ex_valid", 32'(io.ex_valid), 32'(e.v));
        chk("ex_ctrl", 32'({io.ex_wen, io.ex_memread, io.ex_memwrite}),
            32'({e.wen, e.mr, e.mw}));
        chk("ex_idx", 32'({io.ex_opcode, io.ex_src1, io.ex_src2, io.ex_dst}),
            32'({e.op, e.s1, e.s2, e.dst}));
        chk("ex_imm", 32'(io.ex_imm), 32'(e.imm));
        chk("ex_data1", 32'(io.ex_data1), 32'(e.d1));
        chk("ex_data2", 32'(io.ex_data2), 32'(e.d2));
        chk("bubble_cnt", 32'(io.bubble_cnt), 32'(e.cnt));
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_valid"}, 32'(io.ex_valid), 32'd0);
        chk({tag, "_ctrl"},
            32'({io.ex_wen, io.ex_memread, io.ex_memwrite}), 32'd0);
        chk({tag, "_idx"},
            32'({io.ex_opcode, io.ex_src1, io.ex_src2, io.ex_dst}), 32'd0);
        chk({tag, "_data"},
            {io.ex_data1, io.ex_data2}, 32'd0);
        chk({tag, "_imm"}, 32'(io.ex_imm), 32'd0);
        chk({tag, "_bubble"}, 32'(io.bubble_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m   = '0;
        id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        io.wb_dst    = 4'd0;
        io.wb_wen    = 1'b0;
        io.wb_data   = 16'd0;
        io.flush     = 1'b0;
        io.mem_stall = 1'b0;
        #2;
        reset_chk("rst0");
        chk("rst0_stall", 32'(io.stall_id), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // plain loads, then an invalid slot with control bits set
        id(1, 4'h1, 4'd1, 4'd2, 4'd4, 16'h0010, 1, 0, 0, 16'hAAAA, 16'h5555);
        step();
        id(0, 4'h2, 4'd1, 4'd2, 4'd4, 16'h0020, 1, 1, 1, 16'h1111, 16'h2222);
        step();

        // load r3 then dependent add: one bubble then the add loads
        id(1, 4'h8, 4'd1, 4'd0, 4'd3, 16'h0004, 1, 1, 0, 16'h0100, 16'h0);
        step();
        id(1, 4'h1, 4'd3, 4'd2, 4'd5, 16'h0000, 1, 0, 0, 16'h0007, 16'h0009);
        step();
        step();

        // back-to-back loads to r3 reading r3
        id(1, 4'h8, 4'd3, 4'd0, 4'd3, 16'h0002, 1, 1, 0, 16'h0300, 16'h0);
        repeat (5) step();

        // flush coinciding with a hazard
        id(1, 4'h1, 4'd3, 4'd4, 4'd6, 16'h0000, 1, 0, 0, 16'h0003, 16'h0004);
        io.flush = 1'b1;
        step();
        io.flush = 1'b0;

        // memory stall freezes the slot holding 0x1234
        id(1, 4'h1, 4'd1, 4'd2, 4'd6, 16'h0000, 1, 0, 0, 16'h1234, 16'h0042);
        step();
        io.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id(1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               16'($urandom), 1, 1, 1, 16'($urandom), 16'($urandom));
            io.flush = 1'($urandom);
            step();
        end
        io.mem_stall = 1'b0;
        io.flush     = 1'b0;
        id(1, 4'h3, 4'd7, 4'd8, 4'd9, 16'h0055, 0, 0, 1, 16'h7777, 16'h8888);
        step();

        // writeback bypass on each port, and wb_dst=0 never bypasses
        io.wb_wen  = 1'b1;
        io.wb_dst  = 4'd5;
        io.wb_data = 16'hBEEF;
        id(1, 4'h1, 4'd5, 4'd0, 4'd7, 16'h0000, 1, 0, 0, 16'h0000, 16'h00FF);
        step();
        io.wb_dst = 4'd6;
        id(1, 4'h1, 4'd2, 4'd6, 4'd7, 16'h0000, 1, 0, 0, 16'h0101, 16'h2222);
        step();
        io.wb_dst = 4'd0;
        id(1, 4'h1, 4'd0, 4'd5, 4'd7, 16'h0000, 1, 0, 0, 16'h3333, 16'h1111);
        step();
        io.wb_wen = 1'b0;

        // asynchronous reset in mid-cycle with a valid slot and bubbles
        #3;
        rst = 1'b1;
        #1;
        reset_chk("rst_mid");
        m = '0;
        #2;
        rst = 1'b0;

        // counter saturation from a preloaded count
        force dut.bubble_q = 16'hFFFD;
        #1;
        release dut.bubble_q;
        m.cnt = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            id(1, 4'h8, 4'd1, 4'd0, 4'd3, 16'h0000, 1, 1, 0, 16'h0, 16'h0);
            step();
            id(1, 4'h1, 4'd2, 4'd3, 4'd4, 16'h0000, 1, 0, 0, 16'h1, 16'h2);
            step();
        end

        // mixed random traffic
        for (int i = 0; i < 40; i++) begin
            id(1'($urandom), 4'($urandom), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom));
            io.wb_wen    = 1'($urandom);
            io.wb_dst    = 4'($urandom_range(0, 3));
            io.wb_data   = 16'($urandom);
            io.flush     = ($urandom_range(0, 7) == 0);
            io.mem_stall = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode (ID) and execute (EX). It captures the register file's two read ports, the decoded control fields and a valid bit on each clock. It detects load-use hazards, inserts bubbles, and handles flushes and memory stalls. It can optionally bypass the same-cycle writeback value, because the register file has no internal write-to-read bypass.

## Interface
Parameters:
- DW, 16, datapath width (register file data width)
- RW, 4, register index width (16 registers, R0 hardwired zero)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- id_valid  in  1  ID slot holds a real instruction
- id_opcode  in  4  decoded opcode
- id_src1, id_src2  in  RW  source register indices, same values driven to register file SrcReg1/SrcReg2
- id_dst  in  RW  destination register index
- id_imm  in  DW  sign-extended immediate
- id_wen, id_memread, id_memwrite  in  1  decoded control bits
- rf_data1, rf_data2  in  DW  register file SrcData1/SrcData2
- wb_dst  in  RW  writeback DstReg
- wb_wen  in  1  writeback WriteReg
- wb_data  in  DW  writeback DstData
- flush  in  1  taken branch resolved in EX; kill ID instruction
- mem_stall  in  1  memory stage busy; freeze this register
- ex_valid  out  1  EX slot valid
- ex_opcode  out  4  registered opcode
- ex_src1, ex_src2, ex_dst  out  RW  registered indices (src used by EX forwarding)
- ex_imm, ex_data1, ex_data2  out  DW  registered immediate and operands
- ex_wen, ex_memread, ex_memwrite  out  1  registered control; forced 0 when slot invalid
- stall_id  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt  out  16  saturating count of bubbles inserted

## Operation
- Load-use hazard: haz = ex_valid & ex_memread & (ex_dst != 0) & id_valid & (ex_dst == id_src1 | ex_dst == id_src2).
- stall_id = mem_stall | (haz & ~flush).
- Per-edge update priority: rst > mem_stall > flush > haz > load.
  - mem_stall: every register holds, including bubble_cnt. flush and haz are ignored.
  - flush: ex_valid←0. All control outputs ←0. Data fields are don't-care and are cleared to 0.
  - haz: bubble inserted (same as flush). bubble_cnt increments.
  - load: all ex_* ← id_* and ex_valid←id_valid. If id_valid=0, the control bits are loaded as 0.
- Operand capture: ex_dataN ← rf_dataN, or wb_data when bypass is enabled and matched (see Configuration).
- R0: when id_srcN==0, ex_dataN←0 regardless of rf_dataN and bypass.
- bubble_cnt saturates at 16'hFFFF. It counts only haz bubbles, not flushes.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for an edge.

## Timing
- Latency: one cycle from ID inputs to ex_* outputs.
- Reset values: ex_valid=0, all ex_* fields=0, bubble_cnt=0. stall_id reflects its inputs (0 with zeroed state and mem_stall=0).
- Load-use bubble lasts exactly one cycle: the cycle after a bubble, ex_valid=0, so haz=0 and the held instruction loads.
- When a flush and a hazard occur in the same cycle, the flush wins. stall_id=0, so IF/ID advances.
- Back-to-back loads to the same register cause one bubble each time.

## Configuration
- WB_BYPASS_EN defined:
  - if wb_wen & (wb_dst != 0) & (wb_dst == id_srcN), ex_dataN captures wb_data instead of rf_dataN.
  - Both ports are bypassed independently.
- Not defined: ex_dataN always captures rf_dataN. The surrounding design must then schedule writeback in the first half-cycle or insert an extra stall.

## Test plan
- Reset: assert rst mid-cycle with ex_valid=1 → all outputs 0 asynchronously, bubble_cnt=0.
- Load: load ex_dst=R3 (ex_memread=1), then ID `add` with src1=R3 → stall_id=1, next edge ex_valid=0, bubble_cnt=1, following edge the add is loaded.
- Flush priority: flush=1 and haz=1 together → stall_id=0, ex_valid=0, bubble_cnt unchanged.
- Memory stall: mem_stall=1 for 3 cycles with ex_data1=16'h1234 and changing ID inputs → outputs frozen at 16'h1234, then the ID instruction loads on the first edge after mem_stall drops.
- Bypass (WB_BYPASS_EN): wb_wen=1, wb_dst=5, wb_data=16'hBEEF, rf_data1=16'h0000, id_src1=5 → ex_data1=16'hBEEF. Same stimulus without the macro → 16'h0000. With wb_dst=0 → no bypass.
- Saturation: force 65536 hazard bubbles → bubble_cnt stays 16'hFFFF. id_src2=0 with rf_data2=16'h00FF → ex_data2=0.
